// File: rtl/conv3x3_mac.sv
// 3x3 signed convolution MAC: products -> sum+bias -> ReLU/shift/saturate, one window per clock.
// A double-buffered weight/bias loader lets a new kernel be committed between two windows.
module conv3x3_mac #(
  parameter int IMAGE_WIDTH  = 256,
  parameter int IMAGE_HEIGHT = 256,
  parameter int SHIFT        = 7,
  parameter int ACC_W        = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [7:0]  in1,
  input  logic [7:0]  in2,
  input  logic [7:0]  in3,
  input  logic [7:0]  in4,
  input  logic [7:0]  in5,
  input  logic [7:0]  in6,
  input  logic [7:0]  in7,
  input  logic [7:0]  in8,
  input  logic [7:0]  in9,
  input  logic        load_start,
  input  logic [15:0] bias_in,
  input  logic        w_valid,
  input  logic [7:0]  w_data,
  output logic        busy,
  output logic [7:0]  pixel_out,
  output logic        out_valid,
  output logic        frame_done
);

  localparam int FRAME_PIXELS = (IMAGE_WIDTH - 2) * (IMAGE_HEIGHT - 2);
  localparam int CNT_W = $clog2(FRAME_PIXELS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} load_state_t;

  load_state_t       state, state_nxt;
  logic [3:0]        idx;
  logic signed [7:0] w_act [9];
  logic signed [7:0] w_sh  [9];
  logic [15:0]       bias_act, bias_sh;

  logic [7:0]              px [9];
  logic                    v1, v2;
  logic signed [16:0]      prod [9];
  logic [15:0]             bias_s1;
  logic [ACC_W-1:0]        sum, acc;
  logic [ACC_W-1:0]        shifted;
  logic [7:0]              relu_sat;
  logic [CNT_W-1:0]        out_cnt;

  function automatic logic signed [16:0] mul(input logic [7:0] p, input logic signed [7:0] w);
    logic signed [16:0] pe, we;
    pe = {9'd0, p};
    we = {{9{w[7]}}, w};
    return pe * we;
  endfunction

  always_comb begin
    px[0] = in1; px[1] = in2; px[2] = in3;
    px[3] = in4; px[4] = in5; px[5] = in6;
    px[6] = in7; px[7] = in8; px[8] = in9;
  end

  // Loader FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Loader FSM: next state. load_start restarts a load in progress; COMMIT ignores everything.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_start) state_nxt = LOAD;
      LOAD:    if (load_start) state_nxt = LOAD;
               else if (w_valid && idx == 4'd8) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Loader FSM: outputs
  always_comb begin
    busy = (state != IDLE);
  end

  // Shadow bank fills word by word; the active bank swaps in as a whole at the COMMIT edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      bias_sh  <= '0;
      bias_act <= '0;
      for (int i = 0; i < 9; i++) begin
        w_sh[i]  <= '0;
        w_act[i] <= '0;
      end
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (load_start) begin
            idx     <= '0;
            bias_sh <= bias_in;
          end else if (state == LOAD && w_valid) begin
            w_sh[idx] <= w_data;
            idx       <= idx + 4'd1;
          end
        end
        COMMIT: begin
          bias_act <= bias_sh;
          for (int i = 0; i < 9; i++) w_act[i] <= w_sh[i];
        end
        default: ;
      endcase
    end
  end

  // Valid bits travel with the data and advance every cycle; stall=0 marks a window as valid.
  // There is no backpressure: a valid result is presented for exactly one cycle.
  // Bias is captured alongside the products so a commit never mixes banks within one window.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      bias_s1 <= '0;
      for (int i = 0; i < 9; i++) prod[i] <= '0;
    end else begin
      v1 <= ~stall;
      if (!stall) begin
        bias_s1 <= bias_act;
        for (int i = 0; i < 9; i++) prod[i] <= mul(px[i], w_act[i]);
      end
    end
  end

  always_comb begin
    sum = {{(ACC_W-16){bias_s1[15]}}, bias_s1};
    for (int i = 0; i < 9; i++) sum = sum + {{(ACC_W-17){prod[i][16]}}, prod[i]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2  <= 1'b0;
      acc <= '0;
    end else begin
      v2 <= v1;
      if (v1) acc <= sum;
    end
  end

  always_comb begin
    shifted = acc >> SHIFT;
    if (acc[ACC_W-1])                 relu_sat = 8'd0;
    else if (shifted > ACC_W'(255))   relu_sat = 8'hFF;
    else                              relu_sat = shifted[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      pixel_out  <= '0;
      out_cnt    <= '0;
    end else begin
      out_valid  <= v2;
      frame_done <= v2 && (out_cnt == LAST_CNT);
      if (v2) begin
        pixel_out <= relu_sat;
        out_cnt   <= (out_cnt == LAST_CNT) ? '0 : out_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/conv3x3_mac.md
Name: conv3x3_mac

Overview:
- Consumes the 3x3 pixel window produced by the line-buffer window collector and computes one output pixel per valid window.
- Output = signed 3x3 dot product + bias, then ReLU, right shift and saturation to 8 bits.
- Fully pipelined: accepts one window per clock.
- Includes a double-buffered weight/bias loader so kernels change without stopping the stream.

Parameters:
- IMAGE_WIDTH, 256, input row length in pixels.
- IMAGE_HEIGHT, 256, input rows per frame.
- SHIFT, 7, arithmetic right shift applied after ReLU (requantisation).
- ACC_W, 24, accumulator width in bits (minimum 21).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  from collector; 0 = in1..in9 hold a valid window this cycle.
- in1..in9  in  8 each  unsigned window pixels, row-major: in1 top-left, in3 top-right, in9 bottom-right.
- load_start  in  1  pulse; begins a kernel load and latches bias_in.
- bias_in  in  16  signed bias, sampled only on load_start.
- w_valid  in  1  a weight word is present on w_data.
- w_data  in  8  signed weight; words arrive in order w1..w9, matching in1..in9.
- busy  out  1  high while a load is in progress.
- pixel_out  out  8  unsigned result.
- out_valid  out  1  pixel_out valid this cycle.
- frame_done  out  1  one-cycle pulse with the last output pixel of a frame.

Behaviour:
- Reset (rst=1 at a clock edge) clears:
  - all outputs to 0;
  - the active and shadow weight banks and the bias to 0;
  - pipeline valid bits, loader FSM (to IDLE), load index and output counter.
- Pipeline, with window accepted at edge k (stall=0):
  - Edge k: the 9 products pixel*weight are registered. Each pixel is zero-extended to signed 9 bits, giving 17-bit signed products.
  - Edge k+1: the 9 products and the sign-extended bias are summed into ACC_W bits. No overflow is possible: max |sum| < 2^20.
  - Edge k+2: ReLU (negative -> 0), then >>SHIFT, then saturate (>255 -> 255). The result goes to pixel_out, with out_valid=1.
  - Latency is therefore 3 clocks, throughput 1/clk.
- When stall=1, that slot carries valid=0. On cycles with out_valid=0, pixel_out holds its previous value.
- No backpressure. Pipeline valid bits advance every cycle regardless of stall.
- Loader FSM:
  - IDLE: load_start -> LOAD. On the same edge: idx <= 0, bias_shadow <= bias_in, busy <= 1.
  - LOAD: each w_valid writes shadow[idx] and increments idx. A w_valid with idx=8 -> COMMIT.
  - COMMIT (one cycle): active bank <= shadow bank, bias <= bias_shadow, busy <= 0, -> IDLE.
  - A window accepted at the COMMIT edge uses the old weights. A window accepted at the following edge uses the new ones.
  - In-flight windows always finish with the weights they entered with: the products are already registered.
  - w_valid in IDLE or COMMIT is ignored.
  - load_start during LOAD restarts the load: idx <= 0 and the bias is relatched. The active bank is untouched.
- Output counter counts out_valid pulses up to (IMAGE_WIDTH-2)*(IMAGE_HEIGHT-2) - 1.
  - frame_done is asserted together with out_valid on the final count.
  - The counter then wraps to 0.
  - Reset mid-frame clears the counter; the next frame starts from 0.
- Reset mid-load: FSM returns to IDLE and both banks are zeroed.
- Reset mid-pipeline: all in-flight results are discarded and out_valid=0 from the following cycle.

Test Plan:
- Reset check: hold rst 2 cycles with stall=0 and in*=200 -> out_valid=0, pixel_out=0, busy=0. First out_valid appears 3 clocks after rst drops, with pixel_out=0 (zero weights).
- Identity kernel: load w5=1, others 0, bias=0, SHIFT=0. Feed in5=37, then 38, 39 on consecutive cycles -> pixel_out 37, 38, 39 at latency 3, one per clock. Busy is high from load_start through the 9th word and low after COMMIT.
- Arithmetic limits, SHIFT=7, in*=255:
  - all w=127, bias=0: sum=291465 -> 2277 -> saturated 255.
  - all w=-128, bias=100: negative -> 0.
  - in1=in2=in3=128, w1=w2=w3=1, others 0, bias=128 (others in*=0): sum=512 -> pixel_out=4.
- Stall gaps: stall pattern 0,1,1,0,1,0 with distinct windows -> exactly 3 out_valid pulses, each 3 clocks after its accepting edge. Values are correct; pixel_out holds during the gaps.
- Atomic reload: stream continuously with identity weights, then load w5=2 mid-stream -> every output up to the COMMIT-edge window equals in5, every later output equals 2*in5 (saturated). No mixed-bank results. A second load_start issued at idx=4 restarts the load correctly.
- Frame boundary: with IMAGE_WIDTH=IMAGE_HEIGHT=8, feed 36 valid windows -> frame_done pulses once, coincident with the 36th out_valid. A 37th window yields no frame_done. Asserting rst after 20 windows, then 36 more windows -> frame_done on the 36th.
